// File: rtl/mux16_arbiter.sv
// rtl/mux16_arbiter.sv - round-robin arbiter driving the select of a shared 16:1 mux
//
// Purpose: grants one of 16 requesters access to the shared mux, holds the
// grant across a valid/ready handshake, and optionally allows bursts of up to
// MAX_BURST consecutive transfers before handing over.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req[15:0]  request per requester (bit i -> mux select value i)
//   out_ready  downstream accepts the muxed word this cycle
//   sel[3:0]   registered mux select of the granted requester
//   gnt[15:0]  registered one-hot grant, 1<<sel while out_valid, else 0
//   out_valid  registered, muxed word valid for the downstream consumer
//   busy       registered, high while a grant is active

module mux16_arbiter #(
    parameter int MAX_BURST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        out_ready,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        out_valid,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t      state, state_n;
    logic [3:0]  ptr, ptr_n;
    logic [3:0]  burst_cnt, burst_cnt_n;
    logic [3:0]  sel_n;
    logic [15:0] gnt_n;
    logic        out_valid_n;
    logic        busy_n;

    logic [3:0]  arb_base;
    logic        arb_found;
    logic [3:0]  arb_win;

    // Scan upward from base+1 with wrap-around; base itself is checked last,
    // so the last-served requester has the lowest priority.
    function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] base);
        logic       found;
        logic [3:0] win;
        logic [3:0] idx;
        found = 1'b0;
        win   = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            idx = base + 4'(k);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // In GRANT, re-arbitration happens in the same cycle the grant ends, and
    // the index being released becomes the new pointer, so scan from sel.
    always_comb begin
        arb_base             = (state == GRANT) ? sel : ptr;
        {arb_found, arb_win} = rr_pick(req, arb_base);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 4'd15;
            burst_cnt <= 4'd0;
            sel       <= 4'd0;
            gnt       <= 16'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            burst_cnt <= burst_cnt_n;
            sel       <= sel_n;
            gnt       <= gnt_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        burst_cnt_n = burst_cnt;
        sel_n       = sel;
        gnt_n       = gnt;
        out_valid_n = out_valid;
        busy_n      = busy;

        case (state)
            IDLE: begin
                if (arb_found) begin
                    sel_n       = arb_win;
                    gnt_n       = 16'd1 << arb_win;
                    out_valid_n = 1'b1;
                    busy_n      = 1'b1;
                    burst_cnt_n = 4'd1;
                    state_n     = GRANT;
                end
            end

            GRANT: begin
                if (out_valid && out_ready) begin
                    if (req[sel] && (burst_cnt < BURST_MAX)) begin
                        burst_cnt_n = burst_cnt + 4'd1;
                    end else begin
                        // Grant ends on this transfer; hand over with no bubble.
                        ptr_n = sel;
                        if (arb_found) begin
                            sel_n       = arb_win;
                            gnt_n       = 16'd1 << arb_win;
                            burst_cnt_n = 4'd1;
                        end else begin
                            gnt_n       = 16'd0;
                            out_valid_n = 1'b0;
                            busy_n      = 1'b0;
                            burst_cnt_n = 4'd0;
                            state_n     = IDLE;
                        end
                    end
                end else if (!req[sel]) begin
                    // Withdrawal while stalled counts as having been served.
                    ptr_n       = sel;
                    gnt_n       = 16'd0;
                    out_valid_n = 1'b0;
                    busy_n      = 1'b0;
                    burst_cnt_n = 4'd0;
                    state_n     = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux16_arbiter.sv
// tb/tb_mux16_arbiter.sv - directed self-checking bench for mux16_arbiter

module tb_mux16_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        out_ready;

    logic [3:0]  sel1, sel4;
    logic [15:0] gnt1, gnt4;
    logic        ov1, ov4;
    logic        busy1, busy4;

    int total;
    int fails;

    mux16_arbiter #(.MAX_BURST(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel1),
        .gnt       (gnt1),
        .out_valid (ov1),
        .busy      (busy1)
    );

    mux16_arbiter #(.MAX_BURST(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel4),
        .gnt       (gnt4),
        .out_valid (ov4),
        .busy      (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic chk_idle1(input string tag);
        chk({tag, "_ov"},   32'(ov1),   32'd0);
        chk({tag, "_gnt"},  32'(gnt1),  32'd0);
        chk({tag, "_busy"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        total     = 0;
        fails     = 0;
        rst       = 1'b1;
        req       = 16'h0000;
        out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_sel", 32'(sel1), 32'd0);
        chk_idle1("rst");
        chk("rst4_ov", 32'(ov4), 32'd0);
        step();
        rst = 1'b0;

        // Single requester, sticky grant while stalled, release on final transfer
        req = 16'h0001;
        step();
        chk("t1_ov",   32'(ov1),   32'd1);
        chk("t1_sel",  32'(sel1),  32'd0);
        chk("t1_gnt",  32'(gnt1),  32'h0001);
        chk("t1_busy", 32'(busy1), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_hold_gnt", 32'(gnt1), 32'h0001);
            chk("t1_hold_ov",  32'(ov1),  32'd1);
        end
        out_ready = 1'b1;
        req       = 16'h0000;
        step();
        chk_idle1("t1_rel");
        chk("t1_rel_sel", 32'(sel1), 32'd0);

        // Full request, MAX_BURST=1: strict rotation with no gaps
        pulse_rst();
        req       = 16'hFFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step();
            chk("t2_sel", 32'(sel1), 32'(i % 16));
            chk("t2_ov",  32'(ov1),  32'd1);
        end
        chk("t2_gnt", 32'(gnt1), 32'h0002);

        // Two requesters at the wrap boundary
        pulse_rst();
        req       = 16'h8001;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_stall_sel", 32'(sel1), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("t3_sel15", 32'(sel1), 32'd15);
        chk("t3_gnt15", 32'(gnt1), 32'h8000);
        step();
        chk("t3_sel0",  32'(sel1), 32'd0);

        // MAX_BURST=4 bursts with handover
        pulse_rst();
        req       = 16'h0003;
        out_ready = 1'b1;
        begin
            logic [3:0] exp_seq [9];
            exp_seq = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
            for (int i = 0; i < 9; i++) begin
                step();
                chk("t4_sel", 32'(sel4), 32'(exp_seq[i]));
                chk("t4_ov",  32'(ov4),  32'd1);
            end
        end

        // Withdrawal while stalled counts as served; next scan wraps from 6
        pulse_rst();
        req       = 16'h0020;
        out_ready = 1'b0;
        step();
        chk("t5_sel5", 32'(sel1), 32'd5);
        chk("t5_gnt5", 32'(gnt1), 32'h0020);
        req = 16'h0000;
        step();
        chk_idle1("t5_wd");
        req = 16'h0030;
        step();
        chk("t5_sel4", 32'(sel1), 32'd4);
        chk("t5_gnt4", 32'(gnt1), 32'h0010);

        // Asynchronous reset in the middle of a burst
        pulse_rst();
        req       = 16'h0004;
        out_ready = 1'b1;
        step();
        step();
        chk("t6_pre_sel", 32'(sel4), 32'd2);
        chk("t6_pre_ov",  32'(ov4),  32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_ov",   32'(ov4),   32'd0);
        chk("t6_rst_gnt",  32'(gnt4),  32'd0);
        chk("t6_rst_busy", 32'(busy4), 32'd0);
        chk("t6_rst_sel",  32'(sel4),  32'd0);
        rst = 1'b0;
        req = 16'h0001;
        step();
        chk("t6_post_sel", 32'(sel4), 32'd0);
        chk("t6_post_gnt", 32'(gnt4), 32'h0001);
        chk("t6_post_ov",  32'(ov4),  32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/mux16_arbiter.md
# mux16_arbiter

Round-robin arbiter that shares a 16:1 datapath multiplexer (4-bit select) among 16 requesters. It drives the mux select and a one-hot grant vector, and holds the grant across a valid/ready handshake with the downstream consumer. Optional bursts let one requester keep the mux for up to MAX_BURST consecutive transfers. It sits between the requesting units and the shared 16-input mux in the Hunter_RV32 datapath.

## Interface
- MAX_BURST, default 1: maximum consecutive transfers per grant; legal range 1..15.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  16  request per requester; bit i corresponds to mux input i+1 (select value i).
- out_ready  input  1  downstream accepts the muxed word this cycle.
- sel  output  4  registered mux select (index of the granted requester).
- gnt  output  16  registered one-hot grant; equals 1<<sel while out_valid, otherwise 0.
- out_valid  output  1  registered; the muxed word is valid for the downstream consumer.
- busy  output  1  registered; high in GRANT state.

## Operation
- Internal state: fsm {IDLE, GRANT}, ptr[3:0] (last served index), burst_cnt[3:0].
- Reset values: sel=0, gnt=0, out_valid=0, busy=0, ptr=15, burst_cnt=0, fsm=IDLE.
- Arbitration function: scan req starting at ptr+1 (mod 16) upward with wrap-around. The first set bit wins, so the requester at ptr has the lowest priority.
- IDLE: if req!=0, load sel and gnt with the winner, set out_valid=1 and busy=1, set burst_cnt=1, and move to GRANT. Otherwise hold.
- GRANT, transfer (out_valid && out_ready):
  - If req[sel]=1 and burst_cnt<MAX_BURST, keep the grant and increment burst_cnt.
  - Otherwise set ptr<=sel and re-arbitrate in the same cycle.
  - If the re-arbitration finds a requester (the just-served index has lowest priority and may win again only if it is the sole requester), load the new grant with burst_cnt=1 and stay in GRANT. There is no bubble.
  - If req is empty, go to IDLE and clear out_valid, gnt and busy.
- GRANT, no transfer:
  - If req[sel]=1, hold everything; the grant is sticky while out_ready is low.
  - If req[sel]=0 (withdrawal), set ptr<=sel, go to IDLE and clear out_valid, gnt and busy next cycle. The withdrawal counts as served.
- Simultaneous transfer and withdrawal in the same cycle: treat it as a transfer ending the grant (burst ends). Re-arbitrate as above.
- Changes to req for non-granted indices never disturb an active grant.
- sel holds its last value in IDLE. gnt is 0 whenever out_valid=0.

## Timing
- Request to grant latency: 1 cycle. A req sampled at edge N gives out_valid/sel/gnt valid after edge N.
- Back-to-back: after a transfer at edge N, the next grant is visible after edge N with out_valid staying high. Throughput is 1 transfer per cycle when out_ready=1.
- Release to IDLE: out_valid low after the edge that sees the final transfer or withdrawal.
- rst assertion clears all state and outputs immediately, without a clock edge, including mid-grant. The first grant after deassertion needs a rising edge with req!=0.
- All outputs are registered; there is no combinational path from req or out_ready to any output.

## Test plan
- Reset, then req=16'h0001, out_ready=0 → one edge later out_valid=1, sel=0, gnt=16'h0001. These hold for 10 cycles; then out_ready=1 with req=0 → out_valid=0 next cycle.
- MAX_BURST=1, req=16'hFFFF, out_ready=1 continuously → sel sequence 0,1,2,…,15,0,1 on consecutive cycles, out_valid stays 1 with no gaps.
- req=16'h8001, out_ready=0 for 5 cycles → sel=0 is stable. Then out_ready=1 for 2 cycles → sel 0 then 15, then 0 again.
- MAX_BURST=4, req=16'h0003, out_ready=1 → sel sequence 0,0,0,0,1,1,1,1,0. burst_cnt resets on each handover.
- Grant to index 5 with out_ready=0, then drop req[5] → out_valid=0 and gnt=0 next cycle. Then req=16'h0030 → sel=4 (ptr=5, scan wraps from 6).
- rst pulse mid-burst (MAX_BURST=4, burst_cnt=2, out_valid=1) → out_valid, gnt, busy and sel go to 0 without a clock edge. After release with req=16'h0001 → sel=0 (ptr back to 15).
